// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences core load/store requests onto a single-port 32-bit data memory
//   bus. Produces the word address, byte enables and lane-shifted write data,
//   splits misaligned accesses into two aligned beats (when SPLIT_EN=1), and
//   returns LSB-aligned load data with the load-extension select.
//
//   Parameters
//     SPLIT_EN  1: misaligned access runs as two beats; 0: misaligned -> err
//     TIMEOUT   cycles per beat to wait for mem_ack_i before aborting (>=1)
//
//   Ports
//     clk_i, rst_n_i            clock, asynchronous active-low reset
//     start_i, is_store_i       request strobe (taken only in IDLE), direction
//     funct3_i, addr_i, wdata_i RV32 width code, byte address, LSB-aligned data
//     busy_o, done_o, err_o     status; done_o/err_o are one-cycle pulses
//     rdata_align_o, ld_sel_o   load data at bit 0 and extension select
//     mem_req_o, mem_we_o       bus request / write strobe
//     mem_addr_o, mem_be_o      word address, byte enables
//     mem_wdata_o               lane-positioned write data
//     mem_ack_i, mem_rdata_i    beat accepted, read data (valid with ack)
//
//   state | meaning
//   IDLE  | waiting for start_i
//   BEAT0 | first (or only) bus beat; also a one-cycle hold for a rejected request
//   BEAT1 | second beat of a split misaligned access
//   RESP  | done_o pulse cycle, back to IDLE next
module mem_access_ctrl #(
  parameter bit          SPLIT_EN = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_align_o,
  output logic [2:0]  ld_sel_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t        state_q;
  logic          is_store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   d0_q;
  logic          err_pend_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, err_q, mem_req_q, mem_we_q;
  logic [31:0]   rdata_align_q, mem_addr_q, mem_wdata_q;
  logic [2:0]    ld_sel_q;
  logic [3:0]    mem_be_q;

  // Decode source: live inputs while IDLE (so beat 0 can be launched on the
  // accepting edge), latched request afterwards.
  logic [2:0]  f3_s;
  logic        st_s;
  logic [1:0]  off_s;
  logic [31:0] wd_s;
  logic [3:0]  m4_s;
  logic [7:0]  mask8_s;
  logic        misal_s;
  logic        illegal_s;
  logic [63:0] wsh_s;
  logic [63:0] rd64;
  logic [31:0] rdata_d;
  logic [2:0]  ld_sel_d;

  always_comb begin
    f3_s  = funct3_q;
    st_s  = is_store_q;
    off_s = off_q;
    wd_s  = wdata_q;
    if (state_q == IDLE) begin
      f3_s  = funct3_i;
      st_s  = is_store_i;
      off_s = addr_i[1:0];
      wd_s  = wdata_i;
    end

    case (f3_s[1:0])
      2'b00:   m4_s = 4'b0001;
      2'b01:   m4_s = 4'b0011;
      default: m4_s = 4'b1111;
    endcase
    mask8_s   = {4'b0000, m4_s} << off_s;
    misal_s   = |mask8_s[7:4];
    illegal_s = (f3_s == 3'b011) || (f3_s[2:1] == 2'b11) || (st_s && f3_s[2]);
    wsh_s     = {32'd0, wd_s} << {off_s, 3'b000};

    // Second-beat data sits above the first; single-beat loads see zeros above.
    rd64    = (state_q == BEAT1) ? {mem_rdata_i, d0_q} : {32'd0, mem_rdata_i};
    rdata_d = 32'(rd64 >> {off_q, 3'b000});

    case (funct3_q)
      3'b000:  ld_sel_d = 3'b001;
      3'b001:  ld_sel_d = 3'b010;
      3'b010:  ld_sel_d = 3'b011;
      3'b100:  ld_sel_d = 3'b100;
      3'b101:  ld_sel_d = 3'b101;
      default: ld_sel_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      wdata_q       <= 32'd0;
      d0_q          <= 32'd0;
      err_pend_q    <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_align_q <= 32'd0;
      ld_sel_q      <= 3'b000;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_be_q      <= 4'b0000;
      mem_wdata_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            off_q      <= addr_i[1:0];
            wdata_q    <= wdata_i;
            busy_q     <= 1'b1;
            state_q    <= BEAT0;
            if (illegal_s || (misal_s && !SPLIT_EN)) begin
              // Rejected request: sit in BEAT0 one cycle without a bus request.
              err_pend_q <= 1'b1;
            end else begin
              err_pend_q  <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_i;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_be_q    <= mask8_s[3:0];
              mem_wdata_q <= wsh_s[31:0];
              cnt_q       <= CNT_LOAD;
            end
          end
        end

        BEAT0, BEAT1: begin
          if (err_pend_q) begin
            err_pend_q <= 1'b0;
            state_q    <= RESP;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            ld_sel_q   <= 3'b000;
          end else if (mem_ack_i) begin
            if ((state_q == BEAT0) && misal_s) begin
              // Keep req high straight into the second beat; address wraps mod 2^32.
              d0_q        <= mem_rdata_i;
              state_q     <= BEAT1;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_be_q    <= mask8_s[7:4];
              mem_wdata_q <= wsh_s[63:32];
              cnt_q       <= CNT_LOAD;
            end else begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              state_q   <= RESP;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              if (is_store_q) begin
                ld_sel_q <= 3'b000;
              end else begin
                rdata_align_q <= rdata_d;
                ld_sel_q      <= ld_sel_d;
              end
            end
          end else if (cnt_q == '0) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            ld_sel_q  <= 3'b000;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        RESP: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_align_o = rdata_align_q;
  assign ld_sel_o      = ld_sel_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_be_o      = mem_be_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule
